// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_ctrl_pkg                                              |
// | Description : Shared types and field widths for the L1 data cache         |
// |               controller (state encoding, address field sizes).            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package dcache_ctrl_pkg;

   localparam int LINE_W     = 256;
   localparam int WORD_W     = 32;
   localparam int OFFSET_W   = 5;
   localparam int WORD_SEL_W = 3;
   localparam int INDEX_W    = 4;
   localparam int TAG_W      = 23;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      COMPLETE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_sram                                                  |
// | Description : Tag/data/state storage for a direct-mapped cache. Reads are  |
// |               asynchronous; writes are synchronous (full-line refill or    |
// |               single-word update). Valid and dirty clear asynchronously.   |
// | Ports       : clk_i, rst_i          clock, async active-high reset         |
// |               rd_idx -> rd_valid/rd_dirty/rd_tag/rd_line  async read       |
// |               wr_idx, line_we, line_tag, line_data  refill (valid=1,d=0)   |
// |               word_we, word_sel, word_data          word write (dirty=1)   |
// |               dirty_clr                             clear dirty at wr_idx  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcache_sram #(
   parameter int SETS      = 16,
   parameter int IDX_BITS  = 4,
   parameter int TAG_BITS  = 23,
   parameter int LINE_BITS = 256,
   parameter int SEL_BITS  = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_BITS-1:0]  rd_idx,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [TAG_BITS-1:0]  rd_tag,
   output logic [LINE_BITS-1:0] rd_line,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic                 line_we,
   input  logic [TAG_BITS-1:0]  line_tag,
   input  logic [LINE_BITS-1:0] line_data,
   input  logic                 word_we,
   input  logic [SEL_BITS-1:0]  word_sel,
   input  logic [31:0]          word_data,
   input  logic                 dirty_clr
);
   import dcache_ctrl_pkg::*;

   logic [SETS-1:0]      valid;
   logic [SETS-1:0]      dirty;
   logic [TAG_BITS-1:0]  tags [SETS];
   logic [LINE_BITS-1:0] data [SETS];

   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_line  = data[rd_idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (line_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
         end else if (word_we) begin
            dirty[wr_idx] <= 1'b1;
         end else if (dirty_clr) begin
            dirty[wr_idx] <= 1'b0;
         end
      end
   end

   // Tag and data arrays carry no reset: validity alone qualifies them.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         tags[wr_idx] <= line_tag;
         data[wr_idx] <= line_data;
      end else if (word_we) begin
         data[wr_idx][32'(word_sel) * WORD_W +: WORD_W] <= word_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_ctrl                                                  |
// | Description : Direct-mapped, write-back, write-allocate L1 data cache      |
// |               controller. Hits finish in the access cycle; misses stall    |
// |               the pipeline while the victim is written back (if dirty)    |
// |               and the line is refilled over a req/ack line interface.      |
// | Ports       : clk_i, rst_i                 clock, async active-high reset  |
// |               cpu_req_i/we_i/addr_i/wdata_i  MEM-stage access              |
// |               cpu_rdata_o, cpu_stall_o     load data, pipeline freeze      |
// |               mem_req_o/we_o/addr_o/wdata_o  line request to memory        |
// |               mem_rdata_i, mem_ack_i       refill line, completion pulse   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcache_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int LINE_W   = 256,
   parameter int ADDR_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);
   import dcache_ctrl_pkg::*;

   localparam int BYTE_BITS = $clog2(WORD_W / 8);
   localparam int OFF_BITS  = $clog2(LINE_W / 8);
   localparam int IDX_BITS  = $clog2(NUM_SETS);
   localparam int SEL_BITS  = $clog2(LINE_W / WORD_W);
   localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS;

   state_t              state;
   logic [TAG_BITS-1:0] lat_tag;
   logic [IDX_BITS-1:0] lat_idx;
   logic [SEL_BITS-1:0] lat_sel;
   logic                lat_we;
   logic [WORD_W-1:0]   lat_wdata;

   logic [TAG_BITS-1:0] req_tag;
   logic [IDX_BITS-1:0] req_idx;
   logic [SEL_BITS-1:0] req_sel;
   logic [IDX_BITS-1:0] idx;
   logic                rd_valid;
   logic                rd_dirty;
   logic [TAG_BITS-1:0] rd_tag;
   logic [LINE_W-1:0]   rd_line;
   logic                in_idle;
   logic                hit;
   logic                miss;
   logic                line_we;
   logic                word_we;
   logic                dirty_clr;
   logic [SEL_BITS-1:0] word_sel;
   logic [WORD_W-1:0]   word_data;
   logic                unused_byte_bits;

   assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_BITS];
   assign req_idx          = cpu_addr_i[OFF_BITS +: IDX_BITS];
   assign req_sel          = cpu_addr_i[BYTE_BITS +: SEL_BITS];
   assign unused_byte_bits = ^cpu_addr_i[BYTE_BITS-1:0];

   // Outside IDLE the arrays are addressed by the latched miss, so the victim
   // line and tag stay stable for the whole write-back handshake.
   assign idx = (state == IDLE) ? req_idx : lat_idx;

   // Lookup is qualified by reset so outputs show reset values while rst_i is high.
   assign in_idle = (state == IDLE) & ~rst_i;
   assign hit     = in_idle & cpu_req_i & rd_valid & (rd_tag == req_tag);
   assign miss    = in_idle & cpu_req_i & ~hit;

   assign cpu_stall_o = miss | (state == WRITEBACK) | (state == ALLOCATE);

   always_comb begin
      cpu_rdata_o = '0;
      if (hit & ~cpu_we_i) begin
         cpu_rdata_o = rd_line[32'(req_sel) * WORD_W +: WORD_W];
      end else if ((state == COMPLETE) & ~lat_we) begin
         cpu_rdata_o = rd_line[32'(lat_sel) * WORD_W +: WORD_W];
      end
   end

   assign line_we     = (state == ALLOCATE) & mem_ack_i;
   assign dirty_clr   = (state == WRITEBACK) & mem_ack_i;
   assign word_we     = (hit & cpu_we_i) | ((state == COMPLETE) & lat_we);
   assign word_sel    = (state == COMPLETE) ? lat_sel : req_sel;
   assign word_data   = (state == COMPLETE) ? lat_wdata : cpu_wdata_i;
   assign mem_wdata_o = mem_we_o ? rd_line : '0;

   dcache_sram #(
      .SETS      (NUM_SETS),
      .IDX_BITS  (IDX_BITS),
      .TAG_BITS  (TAG_BITS),
      .LINE_BITS (LINE_W),
      .SEL_BITS  (SEL_BITS)
   ) u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_idx    (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_idx    (idx),
      .line_we   (line_we),
      .line_tag  (lat_tag),
      .line_data (mem_rdata_i),
      .word_we   (word_we),
      .word_sel  (word_sel),
      .word_data (word_data),
      .dirty_clr (dirty_clr)
   );

   // Request outputs are registered so they hold steady from assertion
   // through the ack cycle; ack is only looked at in the two request states.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         lat_tag    <= '0;
         lat_idx    <= '0;
         lat_sel    <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  lat_tag   <= req_tag;
                  lat_idx   <= req_idx;
                  lat_sel   <= req_sel;
                  lat_we    <= cpu_we_i;
                  lat_wdata <= cpu_wdata_i;
                  mem_req_o <= 1'b1;
                  if (rd_valid & rd_dirty) begin
                     state      <= WRITEBACK;
                     mem_we_o   <= 1'b1;
                     mem_addr_o <= {rd_tag, req_idx, {OFF_BITS{1'b0}}};
                  end else begin
                     state      <= ALLOCATE;
                     mem_we_o   <= 1'b0;
                     mem_addr_o <= {req_tag, req_idx, {OFF_BITS{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state      <= ALLOCATE;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= {lat_tag, lat_idx, {OFF_BITS{1'b0}}};
               end
            end
            ALLOCATE: begin
               if (mem_ack_i) begin
                  state      <= COMPLETE;
                  mem_req_o  <= 1'b0;
                  mem_addr_o <= '0;
               end
            end
            COMPLETE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dcache_ctrl                                               |
// | Description : Self-checking bench for dcache_ctrl: directed vector table,  |
// |               reset-during-refill sequence, and random accesses checked    |
// |               against a flat-memory reference with a residency model.      |
// | Ports       : none                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dcache_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   always #5 clk_i = ~clk_i;

   dcache_ctrl #(.NUM_SETS(16), .LINE_W(256), .ADDR_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // ---------------- memory side model ----------------
   logic [31:0] mem_words [bit [31:0]];
   logic [31:0] ref_words [bit [31:0]];

   function automatic logic [31:0] bg(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return mem_words.exists(k) ? mem_words[k] : bg(k);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return ref_words.exists(k) ? ref_words[k] : bg(k);
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd(la + 32'(w * 4));
      return l;
   endfunction

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] data;
   } xfer_t;

   xfer_t log_q[$];
   int    ack_lat  = 5;
   bit    mem_auto = 1'b1;
   bit    late_ack = 1'b0;
   int    stab_err = 0;

   // Responds to line requests: ack arrives in the (ack_lat+1)-th request cycle.
   initial begin
      int           cnt;
      logic         h_we;
      logic [31:0]  h_addr;
      logic [255:0] h_wd;
      logic [255:0] line;
      xfer_t        x;
      cnt = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (!mem_auto) begin
            mem_ack_i = late_ack;
            cnt = 0;
         end else if (mem_req_o !== 1'b1) begin
            cnt = 0;
         end else begin
            if (cnt == 0) begin
               h_we = mem_we_o; h_addr = mem_addr_o; h_wd = mem_wdata_o;
            end else if (mem_we_o !== h_we || mem_addr_o !== h_addr ||
                         (h_we && mem_wdata_o !== h_wd)) begin
               stab_err++;
            end
            cnt++;
            if (cnt == ack_lat + 1) begin
               x.we = mem_we_o; x.addr = mem_addr_o; x.data = mem_wdata_o;
               if (mem_we_o) begin
                  for (int w = 0; w < 8; w++)
                     mem_words[mem_addr_o + 32'(w * 4)] = mem_wdata_o[w*32 +: 32];
               end else begin
                  for (int w = 0; w < 8; w++) line[w*32 +: 32] = mem_rd(mem_addr_o + 32'(w * 4));
                  mem_rdata_i = line;
               end
               log_q.push_back(x);
               mem_ack_i = 1'b1;
               cnt = 0;
            end
         end
      end
   end

   // One CPU access held until the pipeline would advance past it.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int stall_cyc, output logic req0);
      @(negedge clk_i);
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
      #1;
      req0 = mem_req_o;
      stall_cyc = 0;
      while (cpu_stall_o === 1'b1 && stall_cyc < 200) begin
         @(posedge clk_i); #1;
         stall_cyc++;
      end
      rd = cpu_rdata_o;
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_stall;
      int          exp_nreq;
      logic        exp_we0;
      logic [31:0] exp_addr0;
      int          wb_sel;
      logic [31:0] wb_word;
   } vec_t;

   vec_t vecs[8];

   bit          m_valid [16];
   bit          m_dirty [16];
   logic [22:0] m_tag   [16];

   initial begin
      logic [31:0] rd;
      int          st;
      logic        req0;
      int          base;

      #200_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          st;
      logic        req0;
      int          base;
      string       nm;

      //        we    addr          wdata         exp_rd        st  n  we0   addr0        sel word
      vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,          32'hDEAD_BEEF, 7,  1, 1'b0, 32'h0000_0100, 0, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0104, 32'h0,          32'hDEAD_BEEF, 0,  0, 1'b0, 32'h0,         0, 32'h0};
      vecs[2] = '{1'b1, 32'h0000_0104, 32'h1234_5678,  32'h0,         0,  0, 1'b0, 32'h0,         0, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_2104, 32'h0,          32'h5A5A_2104, 13, 2, 1'b1, 32'h0000_0100, 1, 32'h1234_5678};
      vecs[4] = '{1'b0, 32'h0000_4104, 32'h0,          32'h5A5A_4104, 7,  1, 1'b0, 32'h0000_4100, 0, 32'h0};
      vecs[5] = '{1'b1, 32'h0000_0208, 32'hCAFE_F00D,  32'h0,         7,  1, 1'b0, 32'h0000_0200, 0, 32'h0};
      vecs[6] = '{1'b0, 32'h0000_0208, 32'h0,          32'hCAFE_F00D, 0,  0, 1'b0, 32'h0,         0, 32'h0};
      vecs[7] = '{1'b0, 32'h0000_2208, 32'h0,          32'h5A5A_2208, 13, 2, 1'b1, 32'h0000_0200, 2, 32'hCAFE_F00D};

      mem_words[32'h104] = 32'hDEAD_BEEF;
      ref_words[32'h104] = 32'hDEAD_BEEF;

      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
      rst_i = 1'b1;
      #1;
      check("rst_rdata", cpu_rdata_o, 0);
      check("rst_stall", cpu_stall_o, 0);
      check("rst_req",   mem_req_o, 0);
      check("rst_we",    mem_we_o, 0);
      check("rst_addr",  mem_addr_o, 0);
      check("rst_wdata", mem_wdata_o, 0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      ack_lat = 5;
      for (int i = 0; i < 8; i++) begin
         base = log_q.size();
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, st, req0);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_stall", i), 256'(st), 256'(vecs[i].exp_stall));
         check($sformatf("vec%0d_nreq", i), 256'(log_q.size() - base), 256'(vecs[i].exp_nreq));
         if (vecs[i].exp_stall == 0) check($sformatf("vec%0d_hit_noreq", i), req0, 0);
         if (vecs[i].exp_nreq > 0 && log_q.size() - base == vecs[i].exp_nreq) begin
            check($sformatf("vec%0d_we0", i), log_q[base].we, vecs[i].exp_we0);
            check($sformatf("vec%0d_addr0", i), log_q[base].addr, vecs[i].exp_addr0);
            if (vecs[i].exp_nreq == 2) begin
               check($sformatf("vec%0d_wbword", i),
                     log_q[base].data[vecs[i].wb_sel*32 +: 32], vecs[i].wb_word);
               check($sformatf("vec%0d_alloc_we", i), log_q[base+1].we, 0);
               check($sformatf("vec%0d_alloc_addr", i), log_q[base+1].addr,
                     {vecs[i].addr[31:5], 5'b0});
            end
         end
         if (vecs[i].we) ref_words[{vecs[i].addr[31:2], 2'b00}] = vecs[i].wdata;
      end

      // ---- reset during ALLOCATE, then a stray ack ----
      mem_auto = 1'b0;
      @(negedge clk_i);
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_6104;
      repeat (3) @(posedge clk_i);
      #1;
      check("pre_rst_req", mem_req_o, 1);
      rst_i = 1'b1;
      #1;
      check("mid_rst_req", mem_req_o, 0);
      check("mid_rst_stall", cpu_stall_o, 0);
      check("mid_rst_rdata", cpu_rdata_o, 0);
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1 late_ack = 1'b1;
      @(posedge clk_i); #1 late_ack = 1'b0;
      check("late_ack_req", mem_req_o, 0);
      check("late_ack_stall", cpu_stall_o, 0);
      @(posedge clk_i); #1;
      check("late_ack_req2", mem_req_o, 0);
      mem_auto = 1'b1;
      ref_words = mem_words;

      base = log_q.size();
      do_access(1'b0, 32'h0000_6104, 32'h0, rd, st, req0);
      check("post_rst_rdata", rd, 32'h5A5A_6104);
      check("post_rst_stall", 256'(st), 256'(7));
      check("post_rst_nreq", 256'(log_q.size() - base), 256'(1));
      if (log_q.size() - base == 1) check("post_rst_addr", log_q[base].addr, 32'h0000_6100);
      base = log_q.size();
      do_access(1'b0, 32'h0000_0104, 32'h0, rd, st, req0);
      check("post_rst_0104_rdata", rd, 32'h1234_5678);
      check("post_rst_0104_stall", 256'(st), 256'(7));
      for (int s = 0; s < 16; s++) begin
         m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_tag[s] = '0;
      end
      m_valid[8] = 1'b1;

      // ---- random accesses against the reference model ----
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [31:0] a;
         logic [31:0] wd;
         logic [3:0]  ix;
         logic [22:0] tg;
         bit          hitp;
         bit          dirtyp;
         logic [31:0] vaddr;
         logic [255:0] vline;
         int          exp_st;
         int          exp_n;

         we = 1'($urandom_range(0, 1));
         a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5) |
              (32'($urandom_range(0, 7)) << 2);
         wd = $urandom;
         ack_lat = $urandom_range(0, 3);
         ix = a[8:5];
         tg = a[31:9];
         hitp   = m_valid[ix] && (m_tag[ix] == tg);
         dirtyp = !hitp && m_valid[ix] && m_dirty[ix];
         vaddr  = {m_tag[ix], ix, 5'b0};
         vline  = ref_line(vaddr);
         exp_st = hitp ? 0 : (dirtyp ? 2 * ack_lat + 3 : ack_lat + 2);
         exp_n  = hitp ? 0 : (dirtyp ? 2 : 1);

         base = log_q.size();
         do_access(we, a, wd, rd, st, req0);
         nm = $sformatf("rnd%0d", n);
         check({nm, "_rdata"}, rd, we ? 32'h0 : ref_rd(a));
         check({nm, "_stall"}, 256'(st), 256'(exp_st));
         check({nm, "_nreq"}, 256'(log_q.size() - base), 256'(exp_n));
         if (exp_n > 0 && log_q.size() - base == exp_n) begin
            if (dirtyp) begin
               check({nm, "_wb_addr"}, log_q[base].addr, vaddr);
               check({nm, "_wb_data"}, log_q[base].data, vline);
            end
            check({nm, "_alloc_we"}, log_q[base + exp_n - 1].we, 0);
            check({nm, "_alloc_addr"}, log_q[base + exp_n - 1].addr, {a[31:5], 5'b0});
         end

         if (!hitp) begin
            m_valid[ix] = 1'b1; m_tag[ix] = tg; m_dirty[ix] = 1'b0;
         end
         if (we) begin
            m_dirty[ix] = 1'b1;
            ref_words[{a[31:2], 2'b00}] = wd;
         end
      end

      check("req_stable", 256'(stab_err), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
